// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA sprite path: default sprite geometry,
// legal pixel depths and a constant-foldable clog2.
package vga_pkg;

  localparam int H_BITS_DEF  = 11;
  localparam int SPR_W_DEF   = 128;
  localparam int SPR_H_DEF   = 128;
  localparam int WORD_W_DEF  = 8;
  localparam int BPP_DEF     = 1;
  localparam int ROM_LAT_DEF = 1;

  // Bit n set means a depth of n bits per pixel is supported (1, 2, 4).
  localparam int BPP_LEGAL_MASK = 32'h0000_0016;
  localparam int BPP_MAX        = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic bit bpp_legal(input int bpp);
    return (bpp >= 1) && (bpp <= BPP_MAX) && (((BPP_LEGAL_MASK >> bpp) & 1) == 1);
  endfunction

endpackage

// File: rtl/vga_pipe_delay.sv
// Fixed-depth shift register with asynchronous clear on every stage; used to
// carry pixel side-band (valid, window, slot) across the ROM read latency.
module vga_pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_sprite_fetch.sv
// Screen coordinate -> sprite bitmap ROM word address and pixel, one pixel per clock.
// Optional horizontal mirroring is built when VGA_SPRITE_MIRROR_EN is defined (adds mirror_x).
module vga_sprite_fetch
  import vga_pkg::*;
#(
  parameter int H_BITS  = H_BITS_DEF,
  parameter int SPR_W   = SPR_W_DEF,
  parameter int SPR_H   = SPR_H_DEF,
  parameter int WORD_W  = WORD_W_DEF,
  parameter int BPP     = BPP_DEF,
  parameter int ROM_LAT = ROM_LAT_DEF,
  localparam int ADDR_W = clog2(SPR_W * SPR_H * BPP / WORD_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [H_BITS-1:0] x,
  input  logic [H_BITS-1:0] y,
  input  logic [H_BITS-1:0] org_x,
  input  logic [H_BITS-1:0] org_y,
`ifdef VGA_SPRITE_MIRROR_EN
  input  logic              mirror_x,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic              pix_valid,
  output logic [BPP-1:0]    pix,
  output logic              in_window
);

  localparam int LXW    = clog2(SPR_W);
  localparam int LYW    = clog2(SPR_H);
  localparam int P_W    = LXW + LYW;
  localparam int PPW    = WORD_W / BPP;
  localparam int SLOT_W = clog2(PPW);
  localparam int SLOT_R = (SLOT_W > 0) ? SLOT_W : 1;
  localparam int DLY_W  = 2 + SLOT_R;

  localparam logic [H_BITS:0] SPR_W_L = (H_BITS+1)'(SPR_W);
  localparam logic [H_BITS:0] SPR_H_L = (H_BITS+1)'(SPR_H);

  // ---------------- stage A: origin subtract and window check ----------------
  logic signed [H_BITS:0] lx_s;
  logic signed [H_BITS:0] ly_s;
  logic                   win_x;
  logic                   win_y;
  logic [LXW-1:0]         lx_t;
  logic [LYW-1:0]         ly_t;

  assign lx_s = $signed({1'b0, x}) - $signed({1'b0, org_x});
  assign ly_s = $signed({1'b0, y}) - $signed({1'b0, org_y});

  // Sign bit rejects sprites hanging off the left/top edge before truncation can alias them.
  assign win_x = !lx_s[H_BITS] && ({1'b0, lx_s[H_BITS-1:0]} < SPR_W_L);
  assign win_y = !ly_s[H_BITS] && ({1'b0, ly_s[H_BITS-1:0]} < SPR_H_L);

`ifdef VGA_SPRITE_MIRROR_EN
  assign lx_t = mirror_x ? ~lx_s[LXW-1:0] : lx_s[LXW-1:0];
`else
  assign lx_t = lx_s[LXW-1:0];
`endif
  assign ly_t = ly_s[LYW-1:0];

  logic           a_valid;
  logic           a_win;
  logic [LXW-1:0] a_lx;
  logic [LYW-1:0] a_ly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      a_win   <= 1'b0;
      a_lx    <= '0;
      a_ly    <= '0;
    end else begin
      a_valid <= in_valid;
      a_win   <= in_valid & win_x & win_y;
      a_lx    <= lx_t;
      a_ly    <= ly_t;
    end
  end

  // ---------------- stage B: linear index split into word address and slot --------
  logic [P_W-1:0]    p_idx;
  logic [ADDR_W-1:0] addr_next;
  logic [SLOT_R-1:0] slot_next;

  assign p_idx     = {a_ly, a_lx};
  assign addr_next = p_idx[P_W-1:SLOT_W];

  if (SLOT_W > 0) begin : g_slot
    assign slot_next = p_idx[SLOT_W-1:0];
  end else begin : g_noslot
    assign slot_next = '0;
  end

  logic              b_valid;
  logic              b_win;
  logic [SLOT_R-1:0] b_slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid  <= 1'b0;
      b_win    <= 1'b0;
      b_slot   <= '0;
      rom_addr <= '0;
    end else begin
      b_valid <= a_valid;
      b_win   <= a_win;
      b_slot  <= slot_next;
      if (a_valid && a_win) rom_addr <= addr_next;
    end
  end

  // ---------------- side-band delay matching the ROM read ----------------
  logic [DLY_W-1:0]  dly_in;
  logic [DLY_W-1:0]  dly_out;
  logic              d_valid;
  logic              d_win;
  logic [SLOT_R-1:0] d_slot;

  assign dly_in = {b_valid, b_win, b_slot};

  vga_pipe_delay #(
    .WIDTH (DLY_W),
    .DEPTH (ROM_LAT)
  ) u_side_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (dly_in),
    .dout  (dly_out)
  );

  assign {d_valid, d_win, d_slot} = dly_out;

  // ---------------- output stage: slot 0 is the MSB end of the word ----------------
  logic [WORD_W-1:0] word_sh;
  logic [BPP-1:0]    pix_sel;

  assign word_sh = rom_data << (32'(d_slot) * BPP);
  assign pix_sel = word_sh[WORD_W-1 -: BPP];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      in_window <= 1'b0;
      pix       <= '0;
    end else begin
      pix_valid <= d_valid;
      in_window <= d_win;
      pix       <= d_win ? pix_sel : '0;
    end
  end

endmodule

// File: tb/tb_vga_sprite_fetch.sv
// Bench for vga_sprite_fetch: a default instance and a BPP=2 / ROM_LAT=3 instance share
// one stimulus stream; each output is compared to a coordinate-level model of the sprite.
module tb_vga_sprite_fetch;

  typedef struct {
    bit v;
    int x;
    int y;
    int ox;
    int oy;
    bit mx;
  } px_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [10:0] x = '0;
  logic [10:0] y = '0;
  logic [10:0] org_x = '0;
  logic [10:0] org_y = '0;
`ifdef VGA_SPRITE_MIRROR_EN
  logic        mirror_x = 1'b0;
`endif

  logic [10:0] rom_addr0;
  logic [7:0]  rom_data0;
  logic        pix_valid0;
  logic [0:0]  pix0;
  logic        in_window0;

  logic [11:0] rom_addr1;
  logic [7:0]  rom_data1;
  logic        pix_valid1;
  logic [1:0]  pix1;
  logic        in_window1;

  logic [7:0] mem0 [0:2047];
  logic [7:0] mem1 [0:4095];
  logic [7:0] r1a, r1b;

  int  n_chk = 0;
  int  n_pass = 0;
  int  edge_n = 0;
  int  exp_addr [2];
  px_t hist [0:2047];
  px_t cur;

  always #5 clk = ~clk;

  vga_sprite_fetch dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .org_x     (org_x),
    .org_y     (org_y),
`ifdef VGA_SPRITE_MIRROR_EN
    .mirror_x  (mirror_x),
`endif
    .rom_addr  (rom_addr0),
    .rom_data  (rom_data0),
    .pix_valid (pix_valid0),
    .pix       (pix0),
    .in_window (in_window0)
  );

  vga_sprite_fetch #(.BPP(2), .ROM_LAT(3)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .org_x     (org_x),
    .org_y     (org_y),
`ifdef VGA_SPRITE_MIRROR_EN
    .mirror_x  (mirror_x),
`endif
    .rom_addr  (rom_addr1),
    .rom_data  (rom_data1),
    .pix_valid (pix_valid1),
    .pix       (pix1),
    .in_window (in_window1)
  );

  // Synchronous ROMs: one register stage per cycle of read latency.
  always @(posedge clk) begin
    rom_data0 <= mem0[rom_addr0];
    r1a       <= mem1[rom_addr1];
    r1b       <= r1a;
    rom_data1 <= r1b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Sprite model: window from the true coordinate difference, pixel from row-major bitmap.
  function automatic void model(input int inst, input px_t e, output bit win,
                                output int addr, output int pix);
    int bpp;
    int ppw;
    int lx;
    int ly;
    int p;
    int slot;
    int word;
    bpp  = (inst == 0) ? 1 : 2;
    ppw  = 8 / bpp;
    lx   = e.x - e.ox;
    ly   = e.y - e.oy;
    win  = e.v && lx >= 0 && lx < 128 && ly >= 0 && ly < 128;
    addr = 0;
    pix  = 0;
    if (win) begin
      if (e.mx) lx = 127 - lx;
      p    = ly * 128 + lx;
      addr = p / ppw;
      slot = p % ppw;
      word = (inst == 0) ? int'(mem0[addr]) : int'(mem1[addr]);
      pix  = (word >> (8 - bpp * (slot + 1))) & ((1 << bpp) - 1);
    end
  endfunction

  task automatic drive(input bit v, input int xi, input int yi, input int oxi, input int oyi,
                       input bit mx);
    cur.v  = v;
    cur.x  = xi & 2047;
    cur.y  = yi & 2047;
    cur.ox = oxi & 2047;
    cur.oy = oyi & 2047;
    in_valid = v;
    x     = 11'(cur.x);
    y     = 11'(cur.y);
    org_x = 11'(cur.ox);
    org_y = 11'(cur.oy);
`ifdef VGA_SPRITE_MIRROR_EN
    cur.mx   = mx;
    mirror_x = mx;
`else
    cur.mx = 1'b0;
    if (mx) cur.mx = 1'b0;
`endif
  endtask

  task automatic tick();
    bit  w;
    int  a;
    int  p;
    px_t e;
    @(posedge clk);
    edge_n++;
    hist[edge_n] = cur;
    if (!rst_n) hist[edge_n].v = 1'b0;
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        model(k, hist[edge_n-1], w, a, p);
        if (w) exp_addr[k] = a;
      end
    end
    #1;
    e = '{default: 0};
    if (edge_n >= 3) e = hist[edge_n-3];
    model(0, e, w, a, p);
    chk("pix_valid0", 32'(pix_valid0), 32'(e.v));
    chk("in_window0", 32'(in_window0), 32'(w));
    chk("pix0", 32'(pix0), 32'(p));
    chk("rom_addr0", 32'(rom_addr0), 32'(exp_addr[0]));
    e = '{default: 0};
    if (edge_n >= 5) e = hist[edge_n-5];
    model(1, e, w, a, p);
    chk("pix_valid1", 32'(pix_valid1), 32'(e.v));
    chk("in_window1", 32'(in_window1), 32'(w));
    chk("pix1", 32'(pix1), 32'(p));
    chk("rom_addr1", 32'(rom_addr1), 32'(exp_addr[1]));
  endtask

  // One pixel followed by idle cycles until both instances have produced it.
  task automatic run_one(input int xi, input int yi, input int oxi, input int oyi, input bit mx,
                         output int a0, output int a1, output int w0, output int p0,
                         output int w1, output int p1);
    drive(1'b1, xi, yi, oxi, oyi, mx);
    tick();
    drive(1'b0, xi, yi, oxi, oyi, 1'b0);
    tick();
    a0 = int'(rom_addr0);
    a1 = int'(rom_addr1);
    tick();
    tick();
    w0 = int'(in_window0);
    p0 = int'(pix0);
    tick();
    tick();
    w1 = int'(in_window1);
    p1 = int'(pix1);
  endtask

  initial begin
    int a0, a1, w0, p0, w1, p1;
    int ox, oy;
    bit v;

    for (int i = 0; i < 2048; i++) mem0[i] = 8'($urandom);
    for (int i = 0; i < 4096; i++) mem1[i] = 8'($urandom);
    mem0[50] = 8'h40;
    mem1[1]  = 8'b00_10_00_00;
    exp_addr[0] = 0;
    exp_addr[1] = 0;
    drive(1'b0, 0, 0, 0, 0, 1'b0);

    tick();
    tick();
    chk("rst_pix_valid0", 32'(pix_valid0), 32'd0);
    chk("rst_rom_addr1", 32'(rom_addr1), 32'd0);
    #3 rst_n = 1'b1;

    run_one(117, 53, 100, 50, 1'b0, a0, a1, w0, p0, w1, p1);
    chk("basic_addr", 32'(a0), 32'd50);
    chk("basic_win", 32'(w0), 32'd1);
    chk("basic_pix", 32'(p0), 32'd1);
    chk("basic_addr_bpp2", 32'(a1), 32'd100);

    run_one(99, 53, 100, 50, 1'b0, a0, a1, w0, p0, w1, p1);
    chk("left_edge_win", 32'(w0), 32'd0);
    chk("left_edge_pix", 32'(p0), 32'd0);
    chk("left_edge_hold", 32'(a0), 32'd50);

    run_one(227, 50, 100, 50, 1'b0, a0, a1, w0, p0, w1, p1);
    chk("right_in_win", 32'(w0), 32'd1);
    chk("right_in_addr", 32'(a0), 32'd15);

    run_one(228, 50, 100, 50, 1'b0, a0, a1, w0, p0, w1, p1);
    chk("right_out_win", 32'(w0), 32'd0);
    chk("right_out_hold", 32'(a0), 32'd15);

    run_one(5, 0, 2000, 0, 1'b0, a0, a1, w0, p0, w1, p1);
    chk("wrap_win", 32'(w0), 32'd0);
    chk("wrap_win_bpp2", 32'(w1), 32'd0);

    run_one(5, 0, 0, 0, 1'b0, a0, a1, w0, p0, w1, p1);
    chk("bpp2_addr", 32'(a1), 32'd1);
    chk("bpp2_win", 32'(w1), 32'd1);
    chk("bpp2_pix", 32'(p1), 32'd2);

`ifdef VGA_SPRITE_MIRROR_EN
    mem0[15] = 8'h01;
    run_one(0, 0, 0, 0, 1'b1, a0, a1, w0, p0, w1, p1);
    chk("mirror_addr", 32'(a0), 32'd15);
    chk("mirror_pix", 32'(p0), 32'd1);
`endif

    // Random stream with bubbles, origin changes and a mid-stream reset.
    ox = 100;
    oy = 50;
    for (int i = 0; i < 300; i++) begin
      if (i % 40 == 0) begin
        ox = $urandom_range(0, 2047);
        oy = $urandom_range(0, 2047);
      end
      if (i == 150) begin
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid0", 32'(pix_valid0), 32'd0);
        chk("async_rst_valid1", 32'(pix_valid1), 32'd0);
        chk("async_rst_addr1", 32'(rom_addr1), 32'd0);
        for (int k = 0; k < 2048; k++) hist[k].v = 1'b0;
        exp_addr[0] = 0;
        exp_addr[1] = 0;
        tick();
        tick();
        #2 rst_n = 1'b1;
      end
      v = ($urandom_range(0, 3) != 0);
      drive(v, ox + int'($urandom_range(0, 148)) - 10, oy + int'($urandom_range(0, 148)) - 10,
            ox, oy, 1'($urandom));
      tick();
    end

    drive(1'b0, 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 8; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_sprite_fetch.md
# vga_sprite_fetch

Parametrised pixel-to-bitmap fetch unit for the VGA path. Takes screen coordinates from the sync/counter block, subtracts a run-time sprite origin and performs a window check. It then generates the bitmap ROM word address and in-word pixel slot, and returns the pixel value once the ROM read completes. The unit is fully pipelined, accepts one pixel per clock, and sits between the VGA timing generator and the colour/output mux.

## Interface
- `H_BITS`, 11: width of screen coordinates and origin.
- `SPR_W`, 128: sprite width in pixels; power of two, at most 2^(H_BITS-1).
- `SPR_H`, 128: sprite height in pixels; power of two.
- `WORD_W`, 8: ROM data width; power of two, at least BPP.
- `BPP`, 1: bits per pixel; one of 1, 2, 4.
- `ROM_LAT`, 1: ROM read latency in cycles, 1..3.
- `ADDR_W`, derived: clog2(SPR_W*SPR_H*BPP/WORD_W); 11 at defaults.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: pixel coordinate valid.
- `x`, `y` in H_BITS: screen coordinates.
- `org_x`, `org_y` in H_BITS: sprite top-left corner, sampled with each pixel.
- `rom_addr` out ADDR_W: registered ROM word address.
- `rom_data` in WORD_W: ROM word, valid ROM_LAT cycles after the `rom_addr` edge.
- `pix_valid` out 1: output pixel valid.
- `pix` out BPP: pixel value.
- `in_window` out 1: pixel lies inside the sprite, aligned with `pix_valid`.

## Operation
- Stage A (edge 1):
  - lx = x − org_x and ly = y − org_y, computed H_BITS+1 wide and signed.
  - win = lx in [0, SPR_W−1] and ly in [0, SPR_H−1].
  - lx and ly are truncated to clog2(SPR_W) and clog2(SPR_H) bits.
- Stage B (edge 2):
  - p = ly*SPR_W + lx.
  - PPW = WORD_W/BPP.
  - `rom_addr` = p / PPW; slot = p % PPW. Both are shifts and masks only; no divider.
  - When win=0 or in_valid=0, `rom_addr` holds its previous value.
- Delay line: valid, win and slot are delayed ROM_LAT cycles to align with `rom_data`.
- Output stage (edge 3+ROM_LAT):
  - slot 0 is the most significant BPP bits of the word: `pix` = rom_data[WORD_W−1−slot*BPP −: BPP].
  - `pix` = 0 when win=0.
  - `pix_valid` = delayed in_valid; `in_window` = delayed win.
- Origin is not range-checked. A partially off-screen sprite must clip correctly through the signed compare.
- No back-pressure: throughput is one pixel per cycle. Bubbles on `in_valid` propagate as bubbles.

## Timing
- Latency from `in_valid` to `pix_valid` is ROM_LAT+3 cycles; 4 at defaults.
- `rom_addr` updates 2 cycles after the sampled input.
- Reset values: `rom_addr`=0, `pix`=0, `pix_valid`=0, `in_window`=0, and all internal pipeline valids=0.
- Reset asserted mid-stream clears all in-flight pixels immediately. The first `pix_valid` after release comes exactly ROM_LAT+3 cycles after the first `in_valid`.
- An origin change takes effect on the first pixel sampled after the change; earlier in-flight pixels keep their old origin.
- Coordinate wrap: lx or ly negative, or at least SPR_W or SPR_H, gives win=0. There is no aliasing from truncation.

## Configuration
- `VGA_SPRITE_MIRROR_EN` defined:
  - Adds input port `mirror_x` (1 bit), sampled with each pixel in stage A.
  - When high, lx is replaced by SPR_W−1−lx after the window check.
- Macro undefined: port absent; no mirroring logic.

## Structure
- Shared package `vga_pkg`: clog2 function, BPP legality constants, and the default sprite geometry constants (SPR_W, SPR_H, WORD_W).
- Sub-module `vga_pipe_delay`: parametrised width × depth shift register with per-stage async reset. It carries valid, win and slot across ROM_LAT.

## Test plan
- Defaults, org=(100,50), in=(117,53):
  - Checks lx=17, ly=3, p=401, so `rom_addr`=50 at cycle 2.
  - With rom_data=8'h40, slot=1: after 4 cycles, `pix`=1, `in_window`=1.
- Window edges at org=(100,50):
  - x=99 gives `in_window`=0, `pix`=0, `rom_addr` held.
  - x=227 is inside; x=228 is outside.
  - org=(2000,0) with x=5 is outside, with no wrap alias.
- BPP=2, org=(0,0), in=(5,0): `rom_addr`=1, slot=1; rom_data=8'b00_10_00_00 gives `pix`=2'b10.
- `VGA_SPRITE_MIRROR_EN`, mirror_x=1, lx=0: maps to lx=127, giving `rom_addr`=15 and slot=7.
- Back-to-back stream of 300 pixels with ROM_LAT=3:
  - `pix_valid` follows the `in_valid` pattern exactly, delayed by 6 cycles.
  - `rst_n` pulsed low at pixel 150 gives zero spurious valids.
